// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared encodings and scoreboard types for the pipeline sequencer
package pipe_hazard_ctrl_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EXE = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic              wen;
    logic [REG_AW-1:0] dest;
    logic              is_load;
    logic              is_div;
  } sb_entry_t;

  // A stage only forwards if it is live, writes a GPR other than $0, and targets idx.
  function automatic logic sb_hit(input logic v, input sb_entry_t e, input logic [REG_AW-1:0] idx);
    return v && e.wen && (e.dest != '0) && (e.dest == idx);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - datapath <-> sequencer handshake and forwarding bundle
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  logic              fs_valid;
  logic [REG_AW-1:0] de_rs;
  logic [REG_AW-1:0] de_rt;
  logic              de_rs_used;
  logic              de_rt_used;
  logic              de_wen;
  logic [REG_AW-1:0] de_dest;
  logic              de_is_load;
  logic              de_is_div;
  logic              flush;

  logic              fs_allowin;
  logic              de_valid;
  logic              exe_valid;
  logic              mem_valid;
  logic              wb_valid;
  logic              de_to_exe;
  logic [1:0]        rs_fwd_sel;
  logic [1:0]        rt_fwd_sel;
  logic              div_busy;

  modport master (
    output fs_valid, de_rs, de_rt, de_rs_used, de_rt_used, de_wen, de_dest,
           de_is_load, de_is_div, flush,
    input  fs_allowin, de_valid, exe_valid, mem_valid, wb_valid, de_to_exe,
           rs_fwd_sel, rt_fwd_sel, div_busy
  );

  modport slave (
    input  fs_valid, de_rs, de_rt, de_rs_used, de_rt_used, de_wen, de_dest,
           de_is_load, de_is_div, flush,
    output fs_allowin, de_valid, exe_valid, mem_valid, wb_valid, de_to_exe,
           rs_fwd_sel, rt_fwd_sel, div_busy
  );

endinterface

// File: rtl/pipe_hazard_ctrl_div_seq.sv
// rtl/pipe_hazard_ctrl_div_seq.sv - multi-cycle divider occupancy FSM gating EXE ready_go
module pipe_div_seq
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY = 33
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic div_enter,
  input  logic exe_div,
  input  logic exe_leave,
  output logic exe_ready_go,
  output logic div_busy
);

  localparam int CW = (DIV_LATENCY > 2) ? $clog2(DIV_LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(DIV_LATENCY - 2);

  div_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;

  // Flush returns to IDLE but leaves the counter alone; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (flush) begin
      state_q <= DIV_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (div_enter) begin
            state_q <= DIV_BUSY;
            cnt_q   <= CNT_INIT;
            busy_q  <= 1'b1;
          end
        end
        DIV_BUSY: begin
          if (cnt_q == '0) begin
            state_q <= DIV_DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DIV_DONE: begin
          if (exe_leave) begin
            done_q <= 1'b0;
            if (div_enter) begin
              state_q <= DIV_BUSY;
              cnt_q   <= CNT_INIT;
            end else begin
              state_q <= DIV_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= DIV_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign exe_ready_go = !exe_div || done_q;
  assign div_busy     = busy_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stage valids, scoreboard, forwarding selects and load-use stall
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY = 33
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave hz
);

  logic      de_valid_q, de_valid_d;
  logic      exe_valid_q, exe_valid_d;
  logic      mem_valid_q, mem_valid_d;
  logic      wb_valid_q, wb_valid_d;
  sb_entry_t exe_sb_q, exe_sb_d;
  sb_entry_t mem_sb_q, mem_sb_d;
  sb_entry_t wb_sb_q, wb_sb_d;

  sb_entry_t de_sb;
  logic      rs_exe_hit, rs_mem_hit, rs_wb_hit;
  logic      rt_exe_hit, rt_mem_hit, rt_wb_hit;
  fwd_sel_e  rs_sel, rt_sel;
  logic      load_use;
  logic      de_ready_go, exe_ready_go;
  logic      wb_allowin, mem_allowin, exe_allowin, de_allowin;
  logic      de_to_exe, exe_to_mem;
  logic      div_busy;
  logic      unused_sb_bits;

  always_comb begin
    de_sb.wen     = hz.de_wen;
    de_sb.dest    = hz.de_dest;
    de_sb.is_load = hz.de_is_load;
    de_sb.is_div  = hz.de_is_div;

    rs_exe_hit = hz.de_rs_used && sb_hit(exe_valid_q, exe_sb_q, hz.de_rs);
    rs_mem_hit = hz.de_rs_used && sb_hit(mem_valid_q, mem_sb_q, hz.de_rs);
    rs_wb_hit  = hz.de_rs_used && sb_hit(wb_valid_q,  wb_sb_q,  hz.de_rs);
    rt_exe_hit = hz.de_rt_used && sb_hit(exe_valid_q, exe_sb_q, hz.de_rt);
    rt_mem_hit = hz.de_rt_used && sb_hit(mem_valid_q, mem_sb_q, hz.de_rt);
    rt_wb_hit  = hz.de_rt_used && sb_hit(wb_valid_q,  wb_sb_q,  hz.de_rt);

    // Youngest producer wins.
    rs_sel = FWD_RF;
    if (rs_exe_hit)      rs_sel = FWD_EXE;
    else if (rs_mem_hit) rs_sel = FWD_MEM;
    else if (rs_wb_hit)  rs_sel = FWD_WB;

    rt_sel = FWD_RF;
    if (rt_exe_hit)      rt_sel = FWD_EXE;
    else if (rt_mem_hit) rt_sel = FWD_MEM;
    else if (rt_wb_hit)  rt_sel = FWD_WB;

    load_use    = exe_sb_q.is_load && (rs_exe_hit || rt_exe_hit);
    de_ready_go = !load_use;

    wb_allowin  = 1'b1;
    mem_allowin = !mem_valid_q || wb_allowin;
    exe_allowin = !exe_valid_q || (exe_ready_go && mem_allowin);
    de_allowin  = !de_valid_q  || (de_ready_go && exe_allowin);

    de_to_exe  = de_valid_q  && de_ready_go  && exe_allowin && !hz.flush;
    exe_to_mem = exe_valid_q && exe_ready_go && mem_allowin && !hz.flush;

    de_valid_d  = de_allowin  ? hz.fs_valid                  : de_valid_q;
    exe_valid_d = exe_allowin ? (de_valid_q && de_ready_go)  : exe_valid_q;
    mem_valid_d = mem_allowin ? (exe_valid_q && exe_ready_go) : mem_valid_q;
    wb_valid_d  = wb_allowin  ? mem_valid_q                  : wb_valid_q;

    exe_sb_d = exe_allowin ? de_sb    : exe_sb_q;
    mem_sb_d = mem_allowin ? exe_sb_q : mem_sb_q;
    wb_sb_d  = wb_allowin  ? mem_sb_q : wb_sb_q;

    // A flush in the same cycle overrides every transfer.
    if (hz.flush) begin
      de_valid_d  = 1'b0;
      exe_valid_d = 1'b0;
      mem_valid_d = 1'b0;
      wb_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      de_valid_q  <= 1'b0;
      exe_valid_q <= 1'b0;
      mem_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      exe_sb_q    <= '0;
      mem_sb_q    <= '0;
      wb_sb_q     <= '0;
    end else begin
      de_valid_q  <= de_valid_d;
      exe_valid_q <= exe_valid_d;
      mem_valid_q <= mem_valid_d;
      wb_valid_q  <= wb_valid_d;
      exe_sb_q    <= exe_sb_d;
      mem_sb_q    <= mem_sb_d;
      wb_sb_q     <= wb_sb_d;
    end
  end

  pipe_div_seq #(
    .DIV_LATENCY (DIV_LATENCY)
  ) u_div_seq (
    .clk          (clk),
    .rst          (rst),
    .flush        (hz.flush),
    .div_enter    (de_to_exe && hz.de_is_div),
    .exe_div      (exe_valid_q && exe_sb_q.is_div),
    .exe_leave    (exe_to_mem),
    .exe_ready_go (exe_ready_go),
    .div_busy     (div_busy)
  );

  assign unused_sb_bits = ^{mem_sb_q.is_load, mem_sb_q.is_div, wb_sb_q.is_load, wb_sb_q.is_div};

  assign hz.fs_allowin = de_allowin;
  assign hz.de_valid   = de_valid_q;
  assign hz.exe_valid  = exe_valid_q;
  assign hz.mem_valid  = mem_valid_q;
  assign hz.wb_valid   = wb_valid_q;
  assign hz.de_to_exe  = de_to_exe;
  assign hz.rs_fwd_sel = rs_sel;
  assign hz.rt_fwd_sel = rt_sel;
  assign hz.div_busy   = div_busy;

endmodule
